// File: rtl/uart_matrix_transmitter.sv
// Serialises cells of a 2x4 W-bit matrix as one start/data/parity/stop frame.
// Ports: clk, rst (async low), row/col/wr_en/wr_data, start/action, tx/busy/done.
module uart_matrix_transmitter #(
  parameter int W   = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         row,
  input  logic [1:0]   col,
  input  logic [3:0]   action,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [W-1:0]  mem [2][4];
  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          r_cur;
  logic          r_hi;
  logic [1:0]    c_cur;
  logic [1:0]    c_lo;
  logic [1:0]    c_hi;
  logic          par_acc;

  logic          act_ok;
  logic          last_bit;
  logic          last_cell;
  logic          nxt_r;
  logic [1:0]    nxt_c;
  logic [BW-1:0] nxt_b;
  logic          nxt_d;
  logic          first_d;
  logic          par_bit;

  always_comb begin
    act_ok    = (action >= 4'd2) && (action <= 4'd5);
    last_bit  = (bit_cnt == BMAX);
    last_cell = (r_cur == r_hi) && (c_cur == c_hi);
    nxt_b     = bit_cnt + 1'b1;
    nxt_r     = r_cur;
    nxt_c     = c_cur + 2'd1;
    // Column wraps back to its low bound; the row can only step 0 -> 1.
    if (c_cur == c_hi) begin
      nxt_r = 1'b1;
      nxt_c = c_lo;
    end
    first_d = mem[r_cur][c_cur][0];
    if (!last_bit) nxt_d = mem[r_cur][c_cur][nxt_b];
    else           nxt_d = mem[nxt_r][nxt_c][0];
    par_bit = (PAR == 2) ? ~par_acc : par_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          mem[r][c] <= '0;
        end
      end
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      r_cur   <= 1'b0;
      r_hi    <= 1'b0;
      c_cur   <= 2'd0;
      c_lo    <= 2'd0;
      c_hi    <= 2'd0;
      par_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && !busy) mem[row][col] <= wr_data;
      if (state == S_IDLE) begin
        if (start && act_ok) begin
          state   <= S_START;
          busy    <= 1'b1;
          tx      <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          par_acc <= 1'b0;
          unique case (1'b1)
            (action == 4'd2): begin
              r_cur <= row;  r_hi <= row;
              c_cur <= col;  c_lo <= col;  c_hi <= col;
            end
            (action == 4'd3): begin
              r_cur <= row;  r_hi <= row;
              c_cur <= 2'd0; c_lo <= 2'd0; c_hi <= 2'd3;
            end
            (action == 4'd4): begin
              r_cur <= 1'b0; r_hi <= 1'b1;
              c_cur <= col;  c_lo <= col;  c_hi <= col;
            end
            (action == 4'd5): begin
              r_cur <= 1'b0; r_hi <= 1'b1;
              c_cur <= 2'd0; c_lo <= 2'd0; c_hi <= 2'd3;
            end
          endcase
        end
      end else if (div_cnt != DMAX) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        unique case (state)
          S_START: begin
            state   <= S_DATA;
            tx      <= first_d;
            par_acc <= par_acc ^ first_d;
          end
          S_DATA: begin
            if (!last_bit) begin
              bit_cnt <= nxt_b;
              tx      <= nxt_d;
              par_acc <= par_acc ^ nxt_d;
            end else if (!last_cell) begin
              bit_cnt <= '0;
              r_cur   <= nxt_r;
              c_cur   <= nxt_c;
              tx      <= nxt_d;
              par_acc <= par_acc ^ nxt_d;
            end else if (PAR != 0) begin
              state <= S_PARITY;
              tx    <= par_bit;
            end else begin
              state <= S_STOP;
              tx    <= 1'b1;
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
          S_STOP: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
